// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: sequencing controller for a 4-way set-associative tag RAM.
// Handles lookup/allocate and invalidate-by-tag requests, owns the per-line
// valid bits and per-set tree-PLRU state, and runs the refill handshake with
// the memory bridge on a miss before writing the new tag.
`timescale 1ns/1ps
module cache_tag_ctrl #(
  parameter int LOG_H   = 8,
  parameter int TAG_LEN = 20,
  parameter int N       = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_op,
  input  logic [LOG_H-1:0]       req_index,
  input  logic [TAG_LEN-1:0]     req_tag,
  input  logic                   flush,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [1:0]             resp_way,
  output logic                   rd_req,
  input  logic                   rd_ready,
  output logic [LOG_H-1:0]       rd_index,
  output logic [TAG_LEN-1:0]     rd_tag,
  input  logic                   rd_done,
  output logic                   tag_we,
  output logic [1:0]             tag_way,
  output logic [LOG_H-1:0]       tag_addr,
  output logic [TAG_LEN-1:0]     tag_din,
  input  logic [N*TAG_LEN-1:0]   tag_dout
);

  localparam int H = 1 << LOG_H;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_REFILL = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;

  // Per-set state: valid bit per way, PLRU bits {b2, b1, b0}.
  logic [N-1:0]         r_valid [H];
  logic [2:0]           r_plru  [H];

  // Captured request and chosen victim.
  logic                 r_op;
  logic [LOG_H-1:0]     r_index;
  logic [TAG_LEN-1:0]   r_tag;
  logic [1:0]           r_victim;

  logic [N-1:0]         w_hit_vec;
  logic                 w_hit;
  logic [1:0]           w_hit_way;
  logic [1:0]           w_victim;
  logic [N-1:0]         w_set_valid;
  logic [2:0]           w_set_plru;
  logic                 w_accept;

  // Tree-PLRU update: point the tree away from the accessed way.
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] way);
    logic [2:0] n;
    n = p;
    case (way)
      2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
      2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
      2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
      default: begin n[0] = 1'b0; n[2] = 1'b0; end
    endcase
    return n;
  endfunction

  // Tree-PLRU victim selection.
  function automatic logic [1:0] plru_pick(input logic [2:0] p);
    if (p[0]) return p[2] ? 2'd3 : 2'd2;
    else      return p[1] ? 2'd1 : 2'd0;
  endfunction

  assign w_set_valid = r_valid[r_index];
  assign w_set_plru  = r_plru[r_index];
  assign w_hit       = |w_hit_vec;
  assign w_accept    = (r_state == S_IDLE) && req_valid && !flush;

  // Tag compare against the selected set; lowest matching way wins.
  always_comb begin
    w_hit_vec = '0;
    w_hit_way = 2'd0;
    for (int i = 0; i < N; i++) begin
      w_hit_vec[i] = w_set_valid[i] && (tag_dout[i*TAG_LEN +: TAG_LEN] == r_tag);
    end
    for (int i = N-1; i >= 0; i--) begin
      if (w_hit_vec[i]) w_hit_way = 2'(i);
    end
  end

  // Victim: lowest invalid way, otherwise the PLRU choice.
  always_comb begin
    w_victim = plru_pick(w_set_plru);
    for (int i = N-1; i >= 0; i--) begin
      if (!w_set_valid[i]) w_victim = 2'(i);
    end
  end

  // State register plus valid/PLRU bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      for (int s = 0; s < H; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && flush) begin
        for (int s = 0; s < H; s++) r_valid[s] <= '0;
      end else if (r_state == S_LOOKUP && w_hit) begin
        if (r_op) r_valid[r_index][w_hit_way] <= 1'b0;
        else      r_plru[r_index] <= plru_touch(w_set_plru, w_hit_way);
      end else if (r_state == S_WRITE) begin
        r_valid[r_index][r_victim] <= 1'b1;
        r_plru[r_index]            <= plru_touch(w_set_plru, r_victim);
      end
    end
  end

  // Request capture and victim latch; outputs gate these by state.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op    <= req_op;
      r_index <= req_index;
      r_tag   <= req_tag;
    end
    if (r_state == S_LOOKUP) r_victim <= w_victim;
  end

  // Next-state and output decode.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_way   = 2'd0;
    rd_req     = 1'b0;
    rd_index   = '0;
    rd_tag     = '0;
    tag_we     = 1'b0;
    tag_way    = 2'd0;
    tag_addr   = '0;
    tag_din    = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = resetn && !flush;
        if (w_accept) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        tag_addr = r_index;
        if (r_op) begin
          resp_valid = 1'b1;
          resp_hit   = w_hit;
          resp_way   = w_hit ? w_hit_way : 2'd0;
          w_next     = S_IDLE;
        end else if (w_hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          resp_way   = w_hit_way;
          w_next     = S_IDLE;
        end else begin
          w_next = S_MISS;
        end
      end
      S_MISS: begin
        rd_req   = 1'b1;
        rd_index = r_index;
        rd_tag   = r_tag;
        if (rd_ready) w_next = S_REFILL;
      end
      S_REFILL: begin
        if (rd_done) w_next = S_WRITE;
      end
      S_WRITE: begin
        tag_we     = 1'b1;
        tag_way    = r_victim;
        tag_addr   = r_index;
        tag_din    = r_tag;
        resp_valid = 1'b1;
        resp_hit   = 1'b0;
        resp_way   = r_victim;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
